// File: rtl/mac_col_drain_if.sv
// AXI-Stream word channel that carries one serialized column result per packet.
interface mac_col_drain_if #(
  parameter int WY = 16
);
  logic [WY-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mac_col_drain.sv
// Drain side of a systolic MAC column: waits for each finished dot product,
// snapshots the R accumulators and streams them out as one AXIS packet.
module mac_col_drain #(
  parameter int R  = 4,
  parameter int WY = 16,
  parameter int LA = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en_in,
  input  logic            m_valid,
  input  logic            m_last,
  input  logic [R*WY-1:0] y,
  output logic            en_arr,
  output logic            stall,
  mac_col_drain_if.master m_axis
);

  localparam int            RW       = (R > 1) ? $clog2(R) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);

  logic [LA-1:0] sr;
  logic          tap;
  logic          captured;
  logic          bank_free;
  logic          capture;
  logic          last_row;
  logic [RW-1:0] row;
  logic [WY-1:0] bank [R];

  assign tap       = sr[LA-1];
  assign last_row  = (row == ROW_LAST);
  // The final beat's handshake frees the bank on the same edge, so a
  // waiting result can be captured without a bubble.
  assign bank_free = ~m_axis.tvalid | (m_axis.tready & last_row);
  assign capture   = tap & ~captured & bank_free;
  assign en_arr    = en_in & ~(tap & ~captured & ~bank_free);
  assign stall     = en_in & ~en_arr;

  // Result tracker: mirrors accumulator latency, advancing only on enabled edges
  generate
    if (LA == 1) begin : g_sr1
      always_ff @(posedge clk) begin
        if (!rstn)       sr <= '0;
        else if (en_arr) sr <= m_valid & m_last;
      end
    end else begin : g_srn
      always_ff @(posedge clk) begin
        if (!rstn)       sr <= '0;
        else if (en_arr) sr <= {sr[LA-2:0], m_valid & m_last};
      end
    end
  endgenerate

  // Capture and serializer control
  always_ff @(posedge clk) begin
    if (!rstn) begin
      captured      <= 1'b0;
      row           <= '0;
      m_axis.tvalid <= 1'b0;
    end else begin
      // A frozen array keeps the same result at the tap; remember it was taken.
      captured <= tap & ~en_arr & (captured | capture);
      if (capture) begin
        m_axis.tvalid <= 1'b1;
        row           <= '0;
      end else if (m_axis.tvalid && m_axis.tready) begin
        if (last_row) m_axis.tvalid <= 1'b0;
        else          row           <= row + RW'(1);
      end
    end
  end

  // Snapshot bank: data only, left unreset
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int r = 0; r < R; r++) bank[r] <= y[r*WY +: WY];
    end
  end

  assign m_axis.tdata = bank[row];
  assign m_axis.tlast = last_row;

endmodule
